// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants, immediate formats and ID/EX record
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
  } id_ex_t;

  // FENCE and SYSTEM are legal but carry no operand immediate here.
  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, LOAD, JALR: imm_type_of = IMM_I;
      STORE:              imm_type_of = IMM_S;
      BRANCH:             imm_type_of = IMM_B;
      LUI, AUIPC:         imm_type_of = IMM_U;
      JAL:                imm_type_of = IMM_J;
      default:            imm_type_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// rtl/id_ex_stage_imm_gen.sv - combinational RV32I immediate generator
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode stage with ID/EX register and load-use stall
// WB_BYPASS_EN: forward same-edge writeback data instead of stalling one cycle.
module id_ex_stage
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, legal;
  logic [31:0] imm, op1, op2;
  logic        ld_hit, wb_hit1, wb_hit2, load_use, advance;
  imm_type_e   imm_type;
  id_ex_t      dec, ex_d, ex_q;
  logic        ex_valid_d, ex_valid_q;

  assign opcode = if_instr[6:0];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  assign rs1_used = !(opcode inside {LUI, AUIPC, JAL});
  assign rs2_used = opcode inside {OP, STORE, BRANCH};
  assign legal    = opcode inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC,
                                   MISC_MEM, SYSTEM};
  assign imm_type = imm_type_of(opcode);

  imm_gen u_imm_gen (
    .instr    (if_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  assign ld_hit  = ex_valid_q && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                   ((rs1_used && ex_q.rd == rs1) || (rs2_used && ex_q.rd == rs2));
  assign wb_hit1 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs1);
  assign wb_hit2 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs2);

`ifdef WB_BYPASS_EN
  assign load_use = ld_hit;
  assign op1      = wb_hit1 ? wb_data : rf_rdata1;
  assign op2      = wb_hit2 ? wb_data : rf_rdata2;
`else
  // The register file commits on this edge; wait one cycle and read the new value.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign load_use = ld_hit || (rs1_used && wb_hit1) || (rs2_used && wb_hit2);
  assign op1      = rf_rdata1;
  assign op2      = rf_rdata2;
`endif

  assign advance  = ex_ready || !ex_valid_q;
  assign id_ready = !load_use && advance;

  always_comb begin
    dec           = '0;
    dec.pc        = if_pc;
    dec.rs1_data  = op1;
    dec.rs2_data  = op2;
    dec.imm       = imm;
    dec.rs1       = rs1;
    dec.rs2       = rs2;
    dec.rd        = rd;
    dec.opcode    = opcode;
    dec.funct3    = if_instr[14:12];
    dec.funct7b5  = if_instr[30];
    dec.mem_read  = (opcode == LOAD);
    dec.mem_write = (opcode == STORE);
    dec.reg_write = (opcode inside {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR}) && (rd != 5'd0);
    dec.illegal   = !legal;
  end

  // Bubbles and flushes only drop valid; payload is overwritten solely on acceptance.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (advance) begin
      if (load_use) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = if_valid;
        if (if_valid) ex_d = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7b5  = ex_q.funct7b5;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage (directed table, sequences, random model)
module tb_id_ex_stage;

  localparam logic [6:0] T_OP = 7'h33, T_OPI = 7'h13, T_LD = 7'h03, T_ST = 7'h23, T_BR = 7'h63;
  localparam logic [6:0] T_JAL = 7'h6f, T_JALR = 7'h67, T_LUI = 7'h37, T_AUI = 7'h17;
  localparam logic [6:0] T_FEN = 7'h0f, T_SYS = 7'h73;

  logic clk = 1'b0;
  logic reset_n;
  logic if_valid, flush, wb_we, ex_ready;
  logic [31:0] if_instr, if_pc, wb_data, rf_rdata1, rf_rdata2;
  logic [4:0]  wb_rd, rf_rs1, rf_rs2;
  logic id_ready, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic ex_funct7b5, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  always @(posedge clk) if (wb_we && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
  assign rf_rdata1 = regs[rf_rs1];
  assign rf_rdata2 = regs[rf_rs2];

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0; ex_ready = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({name, "_data"}, ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
    chk({name, "_ctrl"}, {5'd0, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
        ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal}, 32'd0);
    chk({name, "_id_ready"}, {31'd0, id_ready}, 32'd1);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, mr, mw, rw, ill;
  } fields_t;

  fields_t m;
  logic    m_valid;
  logic    m_ready;

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic signed [31:0] s;
    logic [31:0] sx;
    s  = signed'(ins);
    sx = ins[31] ? 32'hFFFF_FFFF : 32'd0;
    case (ins & 32'h7f)
      32'(T_OPI), 32'(T_LD), 32'(T_JALR): ref_imm = 32'(s >>> 20);
      32'(T_ST):  ref_imm = (sx << 12) | (((ins >> 25) & 32'h7f) << 5) | ((ins >> 7) & 32'h1f);
      32'(T_BR):  ref_imm = (sx << 12) | (((ins >> 7) & 1) << 11) | (((ins >> 25) & 32'h3f) << 5)
                            | (((ins >> 8) & 32'hf) << 1);
      32'(T_LUI), 32'(T_AUI): ref_imm = ins & 32'hFFFF_F000;
      32'(T_JAL): ref_imm = (sx << 20) | (ins & 32'h000F_F000) | (((ins >> 20) & 1) << 11)
                            | (((ins >> 21) & 32'h3ff) << 1);
      default:    ref_imm = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] r);
`ifdef WB_BYPASS_EN
    if (wb_we && wb_rd != 0 && wb_rd == r) return wb_data;
`endif
    return regs[r];
  endfunction

  task automatic model_cycle();
    logic [6:0] op;
    logic [4:0] r1, r2, rdf;
    logic u1, u2, lu, can;
    op  = if_instr[6:0];
    r1  = 5'((if_instr >> 15) & 32'h1f);
    r2  = 5'((if_instr >> 20) & 32'h1f);
    rdf = 5'((if_instr >> 7) & 32'h1f);
    u1  = !(op == T_LUI || op == T_AUI || op == T_JAL);
    u2  = (op == T_OP || op == T_ST || op == T_BR);
    lu  = m_valid && m.mr && m.rd != 0 && ((u1 && m.rd == r1) || (u2 && m.rd == r2));
`ifndef WB_BYPASS_EN
    lu  = lu || (wb_we && wb_rd != 0 && ((u1 && wb_rd == r1) || (u2 && wb_rd == r2)));
`endif
    can     = ex_ready || !m_valid;
    m_ready = !lu && can;
    if (flush) m_valid = 1'b0;
    else if (can) begin
      if (lu) m_valid = 1'b0;
      else begin
        m_valid = if_valid;
        if (if_valid) begin
          m.pc  = if_pc;  m.d1 = ref_operand(r1); m.d2 = ref_operand(r2);
          m.imm = ref_imm(if_instr);
          m.rs1 = r1; m.rs2 = r2; m.rd = rdf; m.op = op;
          m.f3  = if_instr[14:12]; m.f7 = if_instr[30];
          m.mr  = (op == T_LD); m.mw = (op == T_ST);
          m.ill = !(op inside {T_OP, T_OPI, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI, T_AUI,
                               T_FEN, T_SYS});
          m.rw  = (op inside {T_OP, T_OPI, T_LD, T_LUI, T_AUI, T_JAL, T_JALR}) && rdf != 0;
        end
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [31:0] instr, imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, ill;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] pc_hold;
    vecs[0] = '{"addi",   32'hFFF00293, 32'hFFFF_FFFF, 5'd5,  1, 0, 0, 0};
    vecs[1] = '{"lw",     32'h0000A303, 32'h0000_0000, 5'd6,  1, 1, 0, 0};
    vecs[2] = '{"sw",     32'h0020A423, 32'h0000_0008, 5'd8,  0, 0, 1, 0};
    vecs[3] = '{"lui",    32'h12345537, 32'h1234_5000, 5'd10, 1, 0, 0, 0};
    vecs[4] = '{"auipc0", 32'h80000017, 32'h8000_0000, 5'd0,  0, 0, 0, 0};
    vecs[5] = '{"jal",    32'hFF9FF0EF, 32'hFFFF_FFF8, 5'd1,  1, 0, 0, 0};
    vecs[6] = '{"beq",    32'hFE000EE3, 32'hFFFF_FFFC, 5'd29, 0, 0, 0, 0};
    vecs[7] = '{"add",    32'h002303B3, 32'h0000_0000, 5'd7,  1, 0, 0, 0};
    vecs[8] = '{"illegal",32'hFFFFFFFF, 32'h0000_0000, 5'd31, 0, 0, 0, 1};
    vecs[9] = '{"jalr0",  32'h00C08067, 32'h0000_000C, 5'd0,  0, 0, 0, 0};

    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'hA000_0000 + 32'(i * 32'h111);

    idle_inputs();
    if_instr = 32'h0000_0013; if_pc = 32'h0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if_valid = 1'b1; if_instr = vecs[i].instr; if_pc = 32'h100 + 32'(i * 4);
      #1;
      chk({vecs[i].name, "_rf_rs1"}, {27'd0, rf_rs1}, (vecs[i].instr >> 15) & 32'h1f);
      chk({vecs[i].name, "_id_ready"}, {31'd0, id_ready}, 32'd1);
      tick();
      chk({vecs[i].name, "_valid"}, {31'd0, ex_valid}, 32'd1);
      chk({vecs[i].name, "_imm"}, ex_imm, vecs[i].imm);
      chk({vecs[i].name, "_rd"}, {27'd0, ex_rd}, {27'd0, vecs[i].rd});
      chk({vecs[i].name, "_ctrl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
          {28'd0, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].ill});
      chk({vecs[i].name, "_pc"}, ex_pc, 32'h100 + 32'(i * 4));
      chk({vecs[i].name, "_rs1_data"}, ex_rs1_data, regs[(vecs[i].instr >> 15) & 32'h1f]);
      if_valid = 1'b0;
      tick();
    end

    // LW x6 then dependent ADD x7,x6,x2: exactly one bubble
    if_valid = 1'b1; if_instr = 32'h0000A303; if_pc = 32'h200;
    tick();
    if_instr = 32'h002303B3; if_pc = 32'h204;
    #1 chk("lu_id_ready_stall", {31'd0, id_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    #1 chk("lu_id_ready_release", {31'd0, id_ready}, 32'd1);
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_rs1", {27'd0, ex_rs1}, 32'd6);
    chk("lu_add_pc", ex_pc, 32'h204);
    if_valid = 1'b0;
    tick();

    // Writeback to x3 landing on the capture edge of ADDI x4,x3,1
    if_valid = 1'b1; if_instr = 32'h00118213; if_pc = 32'h300;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678;
`ifdef WB_BYPASS_EN
    #1 chk("wb_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    wb_we = 1'b0;
`else
    #1 chk("wb_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    wb_we = 1'b0;
    chk("wb_stall_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
`endif
    chk("wb_valid", {31'd0, ex_valid}, 32'd1);
    chk("wb_rs1_data", ex_rs1_data, 32'h1234_5678);
    if_valid = 1'b0;
    tick();

    // Flush while EX stalls and a load-use is pending
    if_valid = 1'b1; if_instr = 32'h0000A303; if_pc = 32'h400;
    tick();
    if_instr = 32'h002303B3; if_pc = 32'h404; ex_ready = 1'b0; flush = 1'b1;
    #1 chk("flush_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0; ex_ready = 1'b1;
    tick();
    chk("flush_after_add", {27'd0, ex_rd}, 32'd7);
    chk("flush_after_valid", {31'd0, ex_valid}, 32'd1);
    if_valid = 1'b0;
    tick();

    // BEQ then 3 cycles of EX backpressure, then reset mid-stall
    if_valid = 1'b1; if_instr = 32'hFE000EE3; if_pc = 32'h500;
    tick();
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
    pc_hold = ex_pc;
    if_instr = 32'hFFF00293; if_pc = 32'h504; ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, ex_valid}, 32'd1);
      chk("bp_imm", ex_imm, 32'hFFFF_FFFC);
      chk("bp_pc", ex_pc, pc_hold);
    end
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset_mid_stall");
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    tick();
    chk("post_reset_valid", {31'd0, ex_valid}, 32'd0);

    // Randomized run against the reference model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m = '{default: '0};
    m_valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      logic [6:0]  opl [12];
      opl = '{T_OP, T_OPI, T_LD, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI, T_AUI, T_SYS, T_FEN};
      chk("rnd_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("rnd_pc", ex_pc, m.pc);
      chk("rnd_rs1_data", ex_rs1_data, m.d1);
      chk("rnd_rs2_data", ex_rs2_data, m.d2);
      chk("rnd_imm", ex_imm, m.imm);
      chk("rnd_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, m.rs1, m.rs2, m.rd});
      chk("rnd_fields", {21'd0, ex_opcode, ex_funct3, ex_funct7b5}, {21'd0, m.op, m.f3, m.f7});
      chk("rnd_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal},
          {28'd0, m.mr, m.mw, m.rw, m.ill});
      ins = $urandom;
      ins[24:20] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : opl[$urandom_range(0, 11)];
      if_instr = ins;
      if_pc    = $urandom;
      if_valid = ($urandom_range(0, 4) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      wb_we    = ($urandom_range(0, 2) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      #1;
      model_cycle();
      chk("rnd_id_ready", {31'd0, id_ready}, {31'd0, m_ready});
      chk("rnd_rf_rs", {22'd0, rf_rs1, rf_rs2}, {22'd0, ins[19:15], ins[24:20]});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
